fp_mul_unit: RTL and testbench

Iterative single-precision floating-point multiplier for the FPU execute stage. It is the multiplicative counterpart of the FP division unit. It unpacks two `float_t` operands and handles special values. It forms the 48-bit mantissa product with a radix-2 shift-add datapath, normalizes it, and hands an unrounded result plus guard/round/sticky bits to the rounding unit through the same `to_round_unit_o` / `valid_o` / `fu_state_o` contract as the divider.

---
 rtl/fp_mul_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_fp_mul_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_unit.sv
// Iterative single-precision floating-point multiplier.
// Unpacks two IEEE-754 binary32 operands, resolves special values, forms the
// 48-bit significand product with a radix-2 shift-add loop, normalizes it and
// presents an unrounded result plus {guard, round, sticky} to the rounding unit.
// fu_state_o: 1'b0 = FREE (idle), 1'b1 = BUSY.
module fp_mul_unit #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned BIAS   = 127
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clk_en_i,
  input  logic        start_i,
  input  logic [31:0] multiplicand_i,
  input  logic [31:0] multiplier_i,
  output logic [31:0] to_round_unit_o,
  output logic [2:0]  round_bits_o,
  output logic        valid_o,
  output logic        fu_state_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        invalid_op_o
);

  localparam int unsigned ProdW = 2 * MANT_W;
  localparam int unsigned FracW = MANT_W - 1;
  localparam int unsigned CntW  = $clog2(MANT_W);
  localparam logic [CntW-1:0] CntLast = CntW'(MANT_W - 1);
  localparam logic [31:0] CanonNan = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    StIdle,
    StPrepare,
    StMultiply,
    StNormalize,
    StValid
  } state_e;

  state_e state_q, state_d;

  logic [31:0]        opa_q, opa_d, opb_q, opb_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [ProdW-1:0]   acc_q, acc_d;
  logic [MANT_W-1:0]  mplr_q, mplr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic [2:0]         rb_q, rb_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  // Operand fields (operands are already flushed when latched)
  logic [7:0]       ea, eb;
  logic [FracW-1:0] fa, fb;
  logic [MANT_W-1:0] mant_a, mant_b;
  logic a_nan, b_nan, a_snan, b_snan, a_qnan, b_qnan;
  logic a_inf, b_inf, a_zero, b_zero, special, sign_ab;
  logic [31:0] spec_res;
  logic        spec_inv;

  assign ea      = opa_q[30:23];
  assign eb      = opb_q[30:23];
  assign fa      = opa_q[FracW-1:0];
  assign fb      = opb_q[FracW-1:0];
  assign mant_a  = {|ea, fa};
  assign mant_b  = {|eb, fb};
  assign sign_ab = opa_q[31] ^ opb_q[31];
  assign a_nan   = (&ea) && (|fa);
  assign b_nan   = (&eb) && (|fb);
  assign a_snan  = a_nan && !fa[FracW-1];
  assign b_snan  = b_nan && !fb[FracW-1];
  assign a_qnan  = a_nan && fa[FracW-1];
  assign b_qnan  = b_nan && fb[FracW-1];
  assign a_inf   = (&ea) && !(|fa);
  assign b_inf   = (&eb) && !(|fb);
  assign a_zero  = (ea == 8'd0);
  assign b_zero  = (eb == 8'd0);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Special-value result; priority order decides NaN/invalid precedence
  always_comb begin
    spec_res = '0;
    spec_inv = 1'b0;
    if (a_snan || b_snan) begin
      spec_res = CanonNan;
      spec_inv = 1'b1;
    end else if (a_qnan || b_qnan) begin
      spec_res = CanonNan;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res = CanonNan;
      spec_inv = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res = {sign_ab, 8'hFF, {FracW{1'b0}}};
    end else begin
      spec_res = {sign_ab, 31'd0};
    end
  end

  // One shift-add step: add multiplicand into the upper half, then shift right
  logic [MANT_W:0]   acc_sum;
  logic [ProdW-1:0]  acc_step;

  always_comb begin
    acc_sum  = {1'b0, acc_q[ProdW-1:MANT_W]} + (mplr_q[0] ? {1'b0, mant_a} : '0);
    acc_step = {acc_sum, acc_q[MANT_W-1:1]};
  end

  // Normalization of the finished product and exponent range check
  logic signed [9:0] exp_adj;
  logic [FracW-1:0]  mant_n;
  logic [2:0]        grs_n;

  always_comb begin
    if (acc_q[ProdW-1]) begin
      exp_adj = exp_q + 10'sd1;
      mant_n  = acc_q[ProdW-2 -: FracW];
      grs_n   = {acc_q[MANT_W-1], acc_q[MANT_W-2], |acc_q[MANT_W-3:0]};
    end else begin
      exp_adj = exp_q;
      mant_n  = acc_q[ProdW-3 -: FracW];
      grs_n   = {acc_q[MANT_W-2], acc_q[MANT_W-3], |acc_q[MANT_W-4:0]};
    end
  end

  // State register: reset wins over clock enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start_i) state_d = StPrepare;
      StPrepare:   state_d = special ? StValid : StMultiply;
      StMultiply:  if (cnt_q == CntLast) state_d = StNormalize;
      StNormalize: state_d = StValid;
      StValid:     state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    valid_o    = (state_q == StValid);
    fu_state_o = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    opa_d  = opa_q;
    opb_d  = opb_q;
    sign_d = sign_q;
    exp_d  = exp_q;
    acc_d  = acc_q;
    mplr_d = mplr_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    rb_d   = rb_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    inv_d  = inv_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          // Denormals are flushed to a signed zero at capture
          opa_d = (multiplicand_i[30:23] == 8'd0) ? {multiplicand_i[31], 31'd0} : multiplicand_i;
          opb_d = (multiplier_i[30:23] == 8'd0) ? {multiplier_i[31], 31'd0} : multiplier_i;
          res_d = '0;
          rb_d  = '0;
          ovf_d = 1'b0;
          unf_d = 1'b0;
          inv_d = 1'b0;
        end
      end
      StPrepare: begin
        sign_d = sign_ab;
        exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(10'(BIAS));
        acc_d  = '0;
        mplr_d = mant_b;
        cnt_d  = '0;
        if (special) begin
          res_d = spec_res;
          inv_d = spec_inv;
        end
      end
      StMultiply: begin
        acc_d  = acc_step;
        mplr_d = mplr_q >> 1;
        cnt_d  = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
      end
      StNormalize: begin
        if (exp_adj >= 10'sd255) begin
          res_d = {sign_q, 8'hFF, {FracW{1'b0}}};
          ovf_d = 1'b1;
        end else if (exp_adj <= 10'sd0) begin
          res_d = {sign_q, 31'd0};
          unf_d = 1'b1;
        end else begin
          res_d = {sign_q, exp_adj[7:0], mant_n};
          rb_d  = grs_n;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opa_q  <= '0;
      opb_q  <= '0;
      sign_q <= 1'b0;
      exp_q  <= '0;
      acc_q  <= '0;
      mplr_q <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      rb_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      inv_q  <= 1'b0;
    end else if (clk_en_i) begin
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      sign_q <= sign_d;
      exp_q  <= exp_d;
      acc_q  <= acc_d;
      mplr_q <= mplr_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      rb_q   <= rb_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      inv_q  <= inv_d;
    end
  end

  assign to_round_unit_o = res_q;
  assign round_bits_o    = rb_q;
  assign overflow_o      = ovf_q;
  assign underflow_o     = unf_q;
  assign invalid_op_o    = inv_q;

endmodule

// File: tb/tb_fp_mul_unit.sv
// Self-checking bench for fp_mul_unit: directed vectors, a behavioural
// floating-point model feeding an expectation queue, and literal pins.
module tb_fp_mul_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] res;
  logic [2:0]  rb;
  logic        valid, fu_state, ovf, unf, inv;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  rb;
    logic        ov;
    logic        un;
    logic        inv;
  } exp_t;

  exp_t exp_q[$];

  fp_mul_unit #(.MANT_W(24), .BIAS(127)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clk_en_i        (clk_en),
    .start_i         (start),
    .multiplicand_i  (a_in),
    .multiplier_i    (b_in),
    .to_round_unit_o (res),
    .round_bits_o    (rb),
    .valid_o         (valid),
    .fu_state_o      (fu_state),
    .overflow_o      (ovf),
    .underflow_o     (unf),
    .invalid_op_o    (inv)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference multiply built from IEEE rules with integer arithmetic
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic sgn, xs, ys, xq, yq, xi, yi, xz, yz;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy, mant;
    longint unsigned p;
    int e2, sh;
    e   = '0;
    sgn = x[31] ^ y[31];
    ex  = x[30:23];
    ey  = y[30:23];
    fx  = (ex == 0) ? 23'd0 : x[22:0];
    fy  = (ey == 0) ? 23'd0 : y[22:0];
    xs  = (ex == 8'hFF) && (fx != 0) && !fx[22];
    ys  = (ey == 8'hFF) && (fy != 0) && !fy[22];
    xq  = (ex == 8'hFF) && fx[22];
    yq  = (ey == 8'hFF) && fy[22];
    xi  = (ex == 8'hFF) && (fx == 0);
    yi  = (ey == 8'hFF) && (fy == 0);
    xz  = (ex == 0);
    yz  = (ey == 0);
    if (xs || ys) begin
      e.res = 32'h7FC00000; e.inv = 1'b1;
    end else if (xq || yq) begin
      e.res = 32'h7FC00000;
    end else if ((xi && yz) || (yi && xz)) begin
      e.res = 32'h7FC00000; e.inv = 1'b1;
    end else if (xi || yi) begin
      e.res = {sgn, 8'hFF, 23'd0};
    end else if (xz || yz) begin
      e.res = {sgn, 31'd0};
    end else begin
      p  = (64'd8388608 + 64'(fx)) * (64'd8388608 + 64'(fy));
      e2 = int'(ex) + int'(ey) - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24; e2 = e2 + 1;
      end else begin
        sh = 23;
      end
      mant = 23'(p >> sh);
      if (e2 >= 255) begin
        e.res = {sgn, 8'hFF, 23'd0}; e.ov = 1'b1;
      end else if (e2 <= 0) begin
        e.res = {sgn, 31'd0}; e.un = 1'b1;
      end else begin
        e.res = {sgn, 8'(e2), mant};
        e.rb  = {1'(p >> (sh - 1)), 1'(p >> (sh - 2)),
                 ((p & ((64'd1 << (sh - 2)) - 64'd1)) != 0)};
      end
    end
    return e;
  endfunction

  // Compare process: every valid strobe is checked against the model queue
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        check("spurious valid", 32'(valid), 32'd0);
      end else begin
        check("model result", res, exp_q[0].res);
        check("model round_bits", 32'(rb), 32'(exp_q[0].rb));
        check("model overflow", 32'(ovf), 32'(exp_q[0].ov));
        check("model underflow", 32'(unf), 32'(exp_q[0].un));
        check("model invalid", 32'(inv), 32'(exp_q[0].inv));
        if (clk_en) void'(exp_q.pop_front());
      end
    end
  end

  // Launch one operation, measure latency, optionally pin literal results
  task automatic do_op(input string name, input logic [31:0] x, input logic [31:0] y,
                       input int lat, input bit has_lit, input logic [31:0] lit_res,
                       input logic [2:0] lit_rb, input logic [2:0] lit_flags, input bit stall);
    int  n;
    bit  seen;
    @(negedge clk);
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    @(posedge clk);
    n    = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) check({name, " busy"}, 32'(fu_state), 32'd1);
      if (stall) begin
        clk_en = (n >= 10 && n <= 14) ? 1'b0 : 1'b1;
        if (n == 5 || n == 20) begin
          start = 1'b1;
          a_in  = 32'h3F800000;
          b_in  = 32'h3F800000;
        end
      end
      if (valid) seen = 1'b1;
    end
    clk_en = 1'b1;
    start  = 1'b0;
    check({name, " latency"}, 32'(n), 32'(lat));
    if (has_lit && seen) begin
      check({name, " result"}, res, lit_res);
      check({name, " round_bits"}, 32'(rb), 32'(lit_rb));
      check({name, " flags"}, 32'({ovf, unf, inv}), 32'(lit_flags));
    end
    @(negedge clk);
    check({name, " free after"}, 32'(fu_state), 32'd0);
    check({name, " valid one cycle"}, 32'(valid), 32'd0);
  endtask

  task automatic reset_abort();
    int nv;
    @(negedge clk);
    a_in  = 32'h3FC00000;
    b_in  = 32'h40000000;
    start = 1'b1;
    exp_q.push_back(model(a_in, b_in));
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort free", 32'(fu_state), 32'd0);
    check("abort valid", 32'(valid), 32'd0);
    check("abort result", res, 32'd0);
    check("abort outputs", 32'({rb, ovf, unf, inv}), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    nv = 0;
    repeat (35) begin
      @(negedge clk);
      if (valid) nv++;
    end
    check("abort no valid", 32'(nv), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset result", res, 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset state", 32'(fu_state), 32'd0);
    check("reset flags", 32'({rb, ovf, unf, inv}), 32'd0);
    rst = 1'b0;

    do_op("1.5x2", 32'h3FC00000, 32'h40000000, 27, 1, 32'h40400000, 3'b000, 3'b000, 0);
    do_op("ulp sq", 32'h3F800001, 32'h3F800001, 27, 1, 32'h3F800002, 3'b001, 3'b000, 0);
    do_op("neg", 32'hBFC00000, 32'h40000000, 27, 1, 32'hC0400000, 3'b000, 3'b000, 0);
    do_op("ovf", 32'h7F000000, 32'h40000000, 27, 1, 32'h7F800000, 3'b000, 3'b100, 0);
    do_op("unf", 32'h00800000, 32'h3F000000, 27, 1, 32'h00000000, 3'b000, 3'b010, 0);
    do_op("inf x 0", 32'h7F800000, 32'h80000000, 2, 1, 32'h7FC00000, 3'b000, 3'b001, 0);
    do_op("qnan", 32'h7FC00000, 32'h3F800000, 2, 1, 32'h7FC00000, 3'b000, 3'b000, 0);
    do_op("snan", 32'h7F800001, 32'h3F800000, 2, 1, 32'h7FC00000, 3'b000, 3'b001, 0);
    do_op("q x s", 32'h7FC00000, 32'hFF800001, 2, 1, 32'h7FC00000, 3'b000, 3'b001, 0);
    do_op("inf x -2", 32'h7F800000, 32'hC0000000, 2, 1, 32'hFF800000, 3'b000, 3'b000, 0);
    do_op("-0 x 1", 32'h80000000, 32'h3F800000, 2, 1, 32'h80000000, 3'b000, 3'b000, 0);
    do_op("den x inf", 32'h00000001, 32'h7F800000, 2, 1, 32'h7FC00000, 3'b000, 3'b001, 0);
    do_op("-2x-2", 32'hC0000000, 32'hC0000000, 27, 1, 32'h40800000, 3'b000, 3'b000, 0);
    do_op("pi x e", 32'h40490FDB, 32'h402DF854, 27, 0, '0, '0, '0, 0);
    do_op("max frac", 32'h3FFFFFFF, 32'h3FFFFFFF, 27, 0, '0, '0, '0, 0);
    do_op("stall", 32'h3FC00000, 32'h40400000, 32, 1, 32'h40900000, 3'b000, 3'b000, 1);
    reset_abort();
    do_op("after abort", 32'h3FC00000, 32'h40000000, 27, 1, 32'h40400000, 3'b000, 3'b000, 0);
    check("queue drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
